mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 132 +++++++++++++
 tb/tb_mdu_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency HI/LO update with a busy
// window, plus the D-stage stall request for instructions that touch HI/LO.
module mdu_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        E_mdop,
    input  logic [DATA_W-1:0] E_A,
    input  logic [DATA_W-1:0] E_B,
    input  logic              D_md_use,
    output logic              E_busy,
    output logic [DATA_W-1:0] E_HI,
    output logic [DATA_W-1:0] E_LO,
    output logic              D_stall_md
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MUL_LAST = 4'd4;
    localparam logic [3:0] DIV_LAST = 4'd9;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        is_muldiv, is_div, accept, commit;
    logic [DATA_W-1:0] pend_hi, pend_lo;
    logic        pend_wr;
    logic [2*DATA_W-1:0] result;

    // Full-width product; result is {HI, LO}.
    function automatic logic [2*DATA_W-1:0] mul_res(input logic signed_op,
                                                     input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        logic signed [2*DATA_W-1:0] p_s;
        logic        [2*DATA_W-1:0] p_u;
        p_s = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
        p_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        return signed_op ? p_s : p_u;
    endfunction

    // Quotient/remainder as {HI=rem, LO=quo}. A zero divisor is replaced by 1
    // (the result is discarded anyway) and MIN/-1 is handled explicitly so the
    // overflowing quotient wraps instead of relying on the divider.
    function automatic logic [2*DATA_W-1:0] div_res(input logic signed_op,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        logic        [DATA_W-1:0] ub, uq, ur;
        logic signed [DATA_W-1:0] sa, sb, sq, sr;
        ub = (b == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : b;
        sa = a;
        sb = ub;
        if (b == '1) begin
            sq = -sa;
            sr = '0;
        end else begin
            sq = sa / sb;
            sr = sa % sb;
        end
        uq = a / ub;
        ur = a % ub;
        return signed_op ? {sr, sq} : {ur, uq};
    endfunction

    assign is_muldiv = (E_mdop >= OP_MULT) && (E_mdop <= OP_DIVU);
    assign is_div    = (E_mdop == OP_DIV) || (E_mdop == OP_DIVU);
    assign accept    = (state == IDLE) && is_muldiv;
    assign commit    = (state == BUSY) && (cnt == 4'd0);
    assign result    = is_div ? div_res(E_mdop == OP_DIV, E_A, E_B)
                              : mul_res(E_mdop == OP_MULT, E_A, E_B);

    assign E_busy     = (state == BUSY);
    assign D_stall_md = D_md_use && (E_busy || is_muldiv);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = BUSY;
                    cnt_nxt   = is_div ? DIV_LAST : MUL_LAST;
                end
            end
            BUSY: begin
                if (commit) state_nxt = IDLE;
                else        cnt_nxt   = cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // HI/LO and pending result; moves only act in IDLE, commits only in BUSY.
    always_ff @(posedge clk) begin
        if (reset) begin
            E_HI    <= '0;
            E_LO    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            if (accept) begin
                pend_hi <= result[2*DATA_W-1:DATA_W];
                pend_lo <= result[DATA_W-1:0];
                pend_wr <= !(is_div && (E_B == '0));
            end
            if (state == IDLE && E_mdop == OP_MTHI) E_HI <= E_A;
            if (state == IDLE && E_mdop == OP_MTLO) E_LO <= E_A;
            if (commit && pend_wr) begin
                E_HI <= pend_hi;
                E_LO <= pend_lo;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized and directed bench for mdu_ctrl against a countdown/arithmetic
// reference model of the HI/LO unit.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  E_mdop;
    logic [31:0] E_A, E_B;
    logic        D_md_use;
    logic        E_busy, D_stall_md;
    logic [31:0] E_HI, E_LO;

    mdu_ctrl dut (
        .clk(clk), .reset(reset), .E_mdop(E_mdop), .E_A(E_A), .E_B(E_B),
        .D_md_use(D_md_use), .E_busy(E_busy), .E_HI(E_HI), .E_LO(E_LO),
        .D_stall_md(D_stall_md)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_left;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    bit          m_pwr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Plain integer arithmetic: sign/magnitude division, 64-bit products.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ma, mb, q, r;
        longint unsigned ua, ub, p;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = '0;
        case (op)
            3'd1: begin q = sa * sb; res = q; end
            3'd2: begin p = ua * ub; res = p; end
            3'd3: begin
                ma = (sa < 0) ? -sa : sa;
                mb = (sb < 0) ? -sb : sb;
                q = ma / mb;
                r = ma % mb;
                if ((sa < 0) != (sb < 0)) q = -q;
                if (sa < 0) r = -r;
                res = {r[31:0], q[31:0]};
            end
            3'd4: begin
                p = ua / ub;
                res[31:0] = p[31:0];
                p = ua % ub;
                res[63:32] = p[31:0];
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic cyc(input bit rst, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit use_md);
        logic [63:0] r;
        bit busy_op;
        reset = rst; E_mdop = op; E_A = a; E_B = b; D_md_use = use_md;
        busy_op = (op >= 3'd1 && op <= 3'd4);
        #1;
        check("stall", {63'd0, D_stall_md}, {63'd0, use_md && (m_left > 0 || busy_op)});
        @(posedge clk);
        if (rst) begin
            m_left = 0; m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_pwr = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pwr) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (busy_op) begin
            m_pwr = !((op == 3'd3 || op == 3'd4) && b == 32'd0);
            if (m_pwr) begin
                r = ref_result(op, a, b);
                m_phi = r[63:32];
                m_plo = r[31:0];
            end
            m_left = (op <= 3'd2) ? 5 : 10;
        end else if (op == 3'd5) begin
            m_hi = a;
        end else if (op == 3'd6) begin
            m_lo = a;
        end
        #1;
        check("busy", {63'd0, E_busy}, {63'd0, m_left > 0});
        check("hi", {32'd0, E_HI}, {32'd0, m_hi});
        check("lo", {32'd0, E_LO}, {32'd0, m_lo});
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit use_md);
        for (int i = 0; i < n; i++) cyc(0, 3'd0, $urandom, $urandom, use_md);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] b;
        reset = 1'b1; E_mdop = '0; E_A = '0; E_B = '0; D_md_use = 1'b0;
        m_left = 0; m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_pwr = 0;
        @(posedge clk);
        @(negedge clk);
        cyc(1, 3'd1, 32'h5, 32'h7, 1'b0);
        check("rst_hi", {32'd0, E_HI}, 64'd0);
        check("rst_busy", {63'd0, E_busy}, 64'd0);

        cyc(0, 3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        idle(4, 1'b0);
        check("mult_busy4", {63'd0, E_busy}, 64'd1);
        idle(1, 1'b0);
        check("mult_hi", {32'd0, E_HI}, 64'hFFFFFFFF);
        check("mult_lo", {32'd0, E_LO}, 64'hFFFFFFFE);

        cyc(0, 3'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
        idle(5, 1'b0);
        check("multu_hi", {32'd0, E_HI}, 64'h00000001);
        check("multu_lo", {32'd0, E_LO}, 64'hFFFFFFFE);

        cyc(0, 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        idle(9, 1'b0);
        check("div_busy9", {63'd0, E_busy}, 64'd1);
        idle(1, 1'b0);
        check("div_lo", {32'd0, E_LO}, 64'hFFFFFFFD);
        check("div_hi", {32'd0, E_HI}, 64'hFFFFFFFF);

        cyc(0, 3'd4, 32'd7, 32'd0, 1'b0);
        idle(10, 1'b0);
        check("div0_hi", {32'd0, E_HI}, 64'hFFFFFFFF);
        check("div0_lo", {32'd0, E_LO}, 64'hFFFFFFFD);

        cyc(0, 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        idle(10, 1'b0);
        check("ovf_lo", {32'd0, E_LO}, 64'h80000000);
        check("ovf_hi", {32'd0, E_HI}, 64'd0);

        cyc(0, 3'd1, 32'd3, 32'd4, 1'b1);
        idle(5, 1'b1);
        idle(1, 1'b1);
        cyc(0, 3'd1, 32'd3, 32'd4, 1'b0);
        idle(5, 1'b0);

        cyc(0, 3'd5, 32'h12345678, 32'd0, 1'b1);
        check("mthi_hi", {32'd0, E_HI}, 64'h12345678);
        cyc(0, 3'd6, 32'h9ABCDEF0, 32'd0, 1'b1);
        check("mtlo_lo", {32'd0, E_LO}, 64'h9ABCDEF0);

        cyc(0, 3'd3, 32'd100, 32'd7, 1'b0);
        idle(1, 1'b0);
        cyc(0, 3'd1, 32'hDEAD, 32'hBEEF, 1'b1);
        cyc(0, 3'd5, 32'h11111111, 32'd0, 1'b0);
        idle(7, 1'b0);
        check("ign_lo", {32'd0, E_LO}, 64'd14);
        check("ign_hi", {32'd0, E_HI}, 64'd2);

        cyc(0, 3'd3, 32'd1000, 32'd3, 1'b0);
        idle(3, 1'b0);
        cyc(1, 3'd0, 32'd0, 32'd0, 1'b0);
        check("rstb_busy", {63'd0, E_busy}, 64'd0);
        check("rstb_hi", {32'd0, E_HI}, 64'd0);
        check("rstb_lo", {32'd0, E_LO}, 64'd0);
        idle(12, 1'b0);
        cyc(0, 3'd1, 32'd6, 32'd7, 1'b0);
        idle(5, 1'b0);
        check("post_rst_lo", {32'd0, E_LO}, 64'd42);

        for (int i = 0; i < 600; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            cyc($urandom_range(0, 49) == 0, op,
                ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom, b,
                $urandom_range(0, 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
